// File: rtl/pulse_period_chk.sv
// Pulse-train period/high-time checker with lock, sticky error and no-edge timeout.
// Define PULSE_SYNC_EN to add a two-flop synchronizer ahead of the sample register.
module pulse_period_chk #(
    parameter int CLK_PERIOD_TIME = 50,
    parameter int EXP_HIGH_TIME   = 500,
    parameter int EXP_TOTAL_TIME  = 1000,
    parameter int TOL_CLK         = 1,
    parameter int GOOD_NUM        = 4,
    parameter int CNT_W           = 16
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic             PULSE_I,
    output logic [CNT_W-1:0] HIGH_CNT_O,
    output logic [CNT_W-1:0] PERIOD_CNT_O,
    output logic             VALID_O,
    output logic             MATCH_O,
    output logic             LOCK_O,
    output logic             ERR_O,
    output logic             TIMEOUT_O
);

    localparam int EXP_HIGH_CLK  = EXP_HIGH_TIME / CLK_PERIOD_TIME;
    localparam int EXP_TOTAL_CLK = EXP_TOTAL_TIME / CLK_PERIOD_TIME;
    localparam int TIMEOUT_CLK   = 2 * EXP_TOTAL_CLK;
    localparam int GOOD_W        = $clog2(GOOD_NUM + 1);
`ifdef PULSE_SYNC_EN
    localparam int SYNC_STAGES   = 2;
`else
    localparam int SYNC_STAGES   = 0;
`endif
    localparam int PIPE_W        = SYNC_STAGES + 1;

    localparam logic [CNT_W:0]    EXP_HIGH_V  = (CNT_W+1)'(EXP_HIGH_CLK);
    localparam logic [CNT_W:0]    EXP_TOTAL_V = (CNT_W+1)'(EXP_TOTAL_CLK);
    localparam logic [CNT_W:0]    TOL_V       = (CNT_W+1)'(TOL_CLK);
    localparam logic [CNT_W-1:0]  TMO_V       = CNT_W'(TIMEOUT_CLK);
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
    localparam logic [GOOD_W-1:0] GOOD_MAX    = GOOD_W'(GOOD_NUM);

    typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_HIGH, ST_LOW} state_t;

    state_t state_q, state_d;

    logic [PIPE_W-1:0] samp_q, prime_q;
    logic [PIPE_W:0]   samp_shift, prime_shift;
    logic              s, s_dly_q, primed, rise, fall, tmo_hit, report, match_now;

    logic [CNT_W-1:0]  cnt_q, cnt_d, high_cap_q, high_cap_d;
    logic [CNT_W-1:0]  high_out_q, high_out_d, period_q, period_d;
    logic [GOOD_W-1:0] good_q, good_d, good_inc;
    logic              valid_q, valid_d, match_q, match_d, lock_q, lock_d;
    logic              err_q, err_d, tmo_q, tmo_d;
    logic [CNT_W:0]    high_ext, per_ext, high_dev, per_dev;

    // Sample pipeline; prime_q tracks when the last stage holds a real sample
    // so that a level already high at reset release is never seen as a rise.
    assign samp_shift  = {samp_q, PULSE_I};
    assign prime_shift = {prime_q, 1'b1};
    assign s           = samp_shift[PIPE_W];
    assign primed      = prime_shift[PIPE_W];

    assign rise    = s & ~s_dly_q;
    assign fall    = ~s & s_dly_q;
    assign tmo_hit = ((state_q == ST_HIGH) || (state_q == ST_LOW)) &&
                     (cnt_q == TMO_V) && !rise && !fall;
    assign report  = (state_q == ST_LOW) && rise;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            samp_q     <= '0;
            prime_q    <= '0;
            s_dly_q    <= 1'b0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            high_cap_q <= '0;
            high_out_q <= '0;
            period_q   <= '0;
            good_q     <= '0;
            valid_q    <= 1'b0;
            match_q    <= 1'b0;
            lock_q     <= 1'b0;
            err_q      <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            samp_q     <= samp_shift[PIPE_W-1:0];
            prime_q    <= prime_shift[PIPE_W-1:0];
            s_dly_q    <= s;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            high_cap_q <= high_cap_d;
            high_out_q <= high_out_d;
            period_q   <= period_d;
            good_q     <= good_d;
            valid_q    <= valid_d;
            match_q    <= match_d;
            lock_q     <= lock_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (primed && !s) state_d = ST_ARM;
            ST_ARM:  if (rise) state_d = ST_HIGH;
            ST_HIGH: begin
                if (fall)         state_d = ST_LOW;
                else if (tmo_hit) state_d = ST_IDLE;
            end
            ST_LOW: begin
                if (rise)         state_d = ST_HIGH;
                else if (tmo_hit) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Deviations are taken as magnitudes in one extra bit, so no wrap on underflow.
    always_comb begin
        high_ext  = {1'b0, high_cap_q};
        per_ext   = {1'b0, cnt_q};
        high_dev  = (high_ext >= EXP_HIGH_V) ? (high_ext - EXP_HIGH_V) : (EXP_HIGH_V - high_ext);
        per_dev   = (per_ext >= EXP_TOTAL_V) ? (per_ext - EXP_TOTAL_V) : (EXP_TOTAL_V - per_ext);
        match_now = (high_dev <= TOL_V) && (per_dev <= TOL_V);
        good_inc  = (good_q == GOOD_MAX) ? good_q : good_q + 1'b1;
    end

    always_comb begin
        cnt_d      = cnt_q;
        high_cap_d = high_cap_q;
        high_out_d = high_out_q;
        period_d   = period_q;
        good_d     = good_q;
        valid_d    = 1'b0;
        match_d    = match_q;
        lock_d     = lock_q;
        err_d      = err_q;
        tmo_d      = 1'b0;

        if (rise) begin
            cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if ((state_q == ST_HIGH) || (state_q == ST_LOW)) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
        end

        if ((state_q == ST_HIGH) && fall) high_cap_d = cnt_q;

        if (report) begin
            period_d   = cnt_q;
            high_out_d = high_cap_q;
            valid_d    = 1'b1;
            match_d    = match_now;
            if (match_now) begin
                good_d = good_inc;
                lock_d = (good_inc == GOOD_MAX);
            end else begin
                good_d = '0;
                lock_d = 1'b0;
                err_d  = 1'b1;
            end
        end

        if (tmo_hit) begin
            tmo_d  = 1'b1;
            err_d  = 1'b1;
            lock_d = 1'b0;
            good_d = '0;
        end
    end

    assign HIGH_CNT_O   = high_out_q;
    assign PERIOD_CNT_O = period_q;
    assign VALID_O      = valid_q;
    assign MATCH_O      = match_q;
    assign LOCK_O       = lock_q;
    assign ERR_O        = err_q;
    assign TIMEOUT_O    = tmo_q;

endmodule

// File: tb/tb_pulse_period_chk.sv
// Directed bench for pulse_period_chk: lock, mismatch, tolerance, timeout and reset cases.
module tb_pulse_period_chk;

    localparam int CNT_W = 16;
`ifdef PULSE_SYNC_EN
    localparam int EXP_LAT = 4;
`else
    localparam int EXP_LAT = 2;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             pulse;
    logic [CNT_W-1:0] high_cnt, period_cnt;
    logic             valid, match, lock, err, tmo;

    always #5 clk = ~clk;

    pulse_period_chk dut (
        .CLK_I        (clk),
        .RST_I        (rst),
        .PULSE_I      (pulse),
        .HIGH_CNT_O   (high_cnt),
        .PERIOD_CNT_O (period_cnt),
        .VALID_O      (valid),
        .MATCH_O      (match),
        .LOCK_O       (lock),
        .ERR_O        (err),
        .TIMEOUT_O    (tmo)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Monitor: records strobes away from the active edge.
    int               cyc = 0, valid_cnt = 0, to_cnt = 0, run = 0, max_run = 0;
    int               lock_at = -1, last_valid_cyc = 0, last_to_cyc = 0;
    logic             lock_prev = 1'b0;
    logic [CNT_W-1:0] last_high = '0, last_per = '0;
    logic             last_match = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (valid) begin
            valid_cnt++;
            last_high      = high_cnt;
            last_per       = period_cnt;
            last_match     = match;
            last_valid_cyc = cyc;
            run++;
        end else begin
            run = 0;
        end
        if (run > max_run) max_run = run;
        if (tmo) begin
            to_cnt++;
            last_to_cyc = cyc;
        end
        if (lock && !lock_prev && lock_at < 0) lock_at = valid_cnt;
        lock_prev = lock;
    end

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drive(input int h, input int l);
        pulse = 1'b1;
        repeat (h) @(posedge clk);
        #1 pulse = 1'b0;
        repeat (l) @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string pfx);
        check_eq({pfx, "_valid"},  valid,      0);
        check_eq({pfx, "_match"},  match,      0);
        check_eq({pfx, "_lock"},   lock,       0);
        check_eq({pfx, "_err"},    err,        0);
        check_eq({pfx, "_tmo"},    tmo,        0);
        check_eq({pfx, "_high"},   high_cnt,   0);
        check_eq({pfx, "_period"}, period_cnt, 0);
    endtask

    int v0, v1, t0, lat;
    bit found;

    initial begin
        rst   = 1'b1;
        pulse = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // Ideal 10/10 train, 6 periods; latency probed on the second rise.
        drive(10, 10);
        pulse = 1'b1;
        lat   = 0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (valid) found = 1'b1;
        end
        check_eq("valid_latency", lat, EXP_LAT);
        repeat (10 - lat) @(posedge clk);
        #1 pulse = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) drive(10, 10);
        check_eq("ideal_valid_count", valid_cnt, 5);
        check_eq("ideal_high", last_high, 10);
        check_eq("ideal_period", last_per, 20);
        check_eq("ideal_match", last_match, 1);
        check_eq("ideal_lock_at_strobe", lock_at, 4);
        check_eq("ideal_lock", lock, 1);
        check_eq("ideal_err", err, 0);
        check_eq("valid_width", max_run, 1);

        // One long period breaks lock; four good periods restore it.
        v0 = valid_cnt;
        drive(10, 10);
        drive(10, 12);
        drive(10, 10);
        check_eq("long_period", last_per, 22);
        check_eq("long_match", last_match, 0);
        check_eq("long_lock", lock, 0);
        check_eq("long_err", err, 1);
        for (int i = 0; i < 4; i++) drive(10, 10);
        check_eq("relock_lock", lock, 1);
        check_eq("relock_err_sticky", err, 1);
        check_eq("relock_period", last_per, 20);
        check_eq("relock_valid_count", valid_cnt - v0, 7);

        // Tolerance edges on the high time.
        do_reset(2);
        check_eq("rst2_err", err, 0);
        check_eq("rst2_lock", lock, 0);
        repeat (6) @(posedge clk);
        #1;
        drive(10, 10);
        drive(11, 9);
        drive(10, 10);
        check_eq("tol11_high", last_high, 11);
        check_eq("tol11_period", last_per, 20);
        check_eq("tol11_match", last_match, 1);
        check_eq("tol11_err", err, 0);
        drive(12, 8);
        drive(10, 10);
        check_eq("tol12_high", last_high, 12);
        check_eq("tol12_match", last_match, 0);
        check_eq("tol12_err", err, 1);

        // Lock up, then stick low after a rise.
        for (int i = 0; i < 4; i++) drive(10, 10);
        check_eq("pre_tmo_lock", lock, 1);
        t0 = to_cnt;
        drive(10, 50);
        check_eq("tmo_count", to_cnt - t0, 1);
        check_eq("tmo_delay", last_to_cyc - last_valid_cyc, 40);
        check_eq("tmo_lock", lock, 0);
        check_eq("tmo_err", err, 1);
        v1 = valid_cnt;
        for (int i = 0; i < 3; i++) drive(10, 10);
        check_eq("resume_valid_count", valid_cnt - v1, 2);
        check_eq("resume_period", last_per, 20);
        check_eq("resume_tmo_count", to_cnt - t0, 1);

        // Level held high through reset release.
        pulse = 1'b1;
        do_reset(3);
        check_eq("hold_rst_err", err, 0);
        v0 = valid_cnt;
        drive(15, 10);
        check_eq("hold_no_report", valid_cnt - v0, 0);
        drive(10, 10);
        check_eq("hold_arm_no_report", valid_cnt - v0, 0);
        drive(10, 10);
        check_eq("hold_first_report", valid_cnt - v0, 1);
        check_eq("hold_high", last_high, 10);
        check_eq("hold_period", last_per, 20);

        // One-cycle reset in the middle of a high phase.
        pulse = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_eq("pre_midrst_match", match, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_zero_outputs("midrst");
        v0 = valid_cnt;
        repeat (5) @(posedge clk);
        #1 pulse = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        drive(10, 10);
        check_eq("midrst_no_report", valid_cnt - v0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
